mac_tx_framer: RTL and testbench
================================

Name: mac_tx_framer

Overview:
- MAC-side transmit framer that sits directly upstream of the PHY pair transceiver.
- Buffers one payload from the client, wraps it in a header and checksum, and streams it to the PHY byte interface (D_TX / D_TX_ready) once the PHY reports the bus idle (IB).
- Handles collisions (CD) and missing acknowledgements with randomized binary-exponential backoff and bounded retries.

Parameters:
- MY_ADDR, 8'h11, source address placed in header byte 1.
- MAX_LEN, 64, payload buffer depth in bytes (1..255).
- MAX_RETRY, 7, retransmissions allowed after the first attempt before the frame is dropped.
- SLOT_CYCLES, 256, clk_40mhz cycles per backoff slot.
- RESULT_TIMEOUT, 4096, cycles allowed after the last byte for TX_success or CD.
- LFSR_SEED, 16'hACE1, nonzero reset value of the 16-bit backoff LFSR (taps 16,14,13,11).

Ports:
- clk_40mhz  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- s_data  in  8  client payload byte.
- s_valid  in  1  s_data valid.
- s_last  in  1  marks final payload byte.
- s_ready  out  1  framer accepts a byte this cycle.
- dest_addr  in  8  destination; sampled with the first accepted payload byte.
- D_TX  out  8  byte to PHY.
- D_TX_ready  out  1  D_TX valid; PHY samples one byte per cycle while high.
- IB  in  1  PHY idle/bus-free.
- CD  in  1  PHY collision detect.
- TX_success  in  1  PHY frame-delivered pulse.
- busy  out  1  frame held (any state except IDLE).
- done  out  1  one-cycle pulse: frame delivered.
- fail  out  1  one-cycle pulse: frame dropped.
- retry_count  out  4  attempts made so far for the current frame, minus one.

Behaviour:
- All outputs are registered.
- Reset values: s_ready=1, D_TX=0, D_TX_ready=0, busy=0, done=0, fail=0, retry_count=0, LFSR=LFSR_SEED, state=IDLE. Reset mid-operation discards the buffer and any in-progress transmission.
- Frame format: DEST, MY_ADDR, LEN (payload byte count), payload[0..LEN-1], CHK.
  - CHK = bitwise NOT of the mod-256 sum of all preceding frame bytes.
- States:
  - IDLE: s_ready=1. An accepted byte (s_valid & s_ready) is written to buf[0], latches dest_addr, and moves to LOAD; if s_last is also set, go straight to WAIT_IDLE with LEN=1.
  - LOAD: s_ready=1; bytes are written sequentially. An accepted byte with s_last, or the MAX_LEN-th accepted byte, ends the load (LEN = count) and moves to WAIT_IDLE. s_ready drops the cycle after the last byte is accepted and stays 0 until the next IDLE.
  - WAIT_IDLE: when IB=1 is sampled, D_TX_ready=1 and D_TX=DEST on the next cycle; go to SEND.
  - SEND: one byte per cycle, contiguous, with no gaps: DEST, SRC, LEN, payload, CHK (LEN+4 cycles high). D_TX_ready=0 the cycle after CHK; go to WAIT_RESULT.
    - CD=1 during SEND: D_TX_ready=0 on the next cycle, abort, go to attempt-fail.
    - IB changes during SEND are ignored.
  - WAIT_RESULT: TX_success -> done pulse, go to IDLE. CD or timeout expiry -> attempt-fail. If CD and TX_success arrive in the same cycle, CD wins.
  - Attempt-fail:
    - If retry_count == MAX_RETRY: fail pulse, go to IDLE.
    - Otherwise retry_count+1, k = LFSR[9:0] & (2^min(retry_count_new,10) - 1), wait k*SLOT_CYCLES cycles in BACKOFF, then go to WAIT_IDLE.
    - k=0 goes to WAIT_IDLE the next cycle.
    - The buffer is retained for retransmission; the header and CHK are regenerated identically.
- LFSR advances every cycle and is never reset except by reset.
- retry_count clears on entry to IDLE.
- done and fail never assert together.
- busy=0 only in IDLE.

Test Plan:
- MY_ADDR=8'h11, dest 8'h22, payload 00..3F (s_last on 3F), IB=1, TX_success 10 cycles after end -> D_TX sequence 22,11,40,00..3F,AC; D_TX_ready high exactly 68 contiguous cycles; done pulses once; retry_count stays 0.
- 1-byte payload 5A with s_last, dest 01 -> frame 01,11,01,5A,92 over 5 cycles; s_ready low until done.
- CD asserted on the 6th byte of the first attempt, TX_success on the second -> D_TX_ready drops 1 cycle after CD; backoff is a multiple of 256 cycles (0 or 256); retransmitted frame is byte-identical; retry_count=1; single done.
- CD on every attempt -> exactly 8 transmissions; fail pulses once after the 8th; retry_count reaches 7; no done.
- 70 bytes offered without s_last, MAX_LEN=64 -> LEN=8'h40 sent; s_ready low after byte 64 is accepted; bytes 65..70 are not accepted.
- Reset asserted mid-SEND -> D_TX_ready, busy and done are 0 immediately (asynchronous); the next frame starts cleanly at DEST.

Source files
------------

// File: rtl/mac_tx_framer.sv
// MAC transmit framer: buffers one client payload, wraps it as DEST/SRC/LEN/payload/CHK
// and streams it to the PHY byte interface with collision backoff and bounded retries.
module mac_tx_framer #(
    parameter logic [7:0]  MY_ADDR        = 8'h11,
    parameter int          MAX_LEN        = 64,
    parameter int          MAX_RETRY      = 7,
    parameter int          SLOT_CYCLES    = 256,
    parameter int          RESULT_TIMEOUT = 4096,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic       clk_40mhz,
    input  logic       reset,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    input  logic [7:0] dest_addr,
    output logic [7:0] D_TX,
    output logic       D_TX_ready,
    input  logic       IB,
    input  logic       CD,
    input  logic       TX_success,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [3:0] retry_count
);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int BW = $clog2(1024 * SLOT_CYCLES + 1);
    localparam int TW = $clog2(RESULT_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WAIT_IDLE, S_SEND, S_WAIT_RESULT, S_BACKOFF
    } state_t;

    state_t          r_state, w_state_next;
    logic [7:0]      r_dest, w_dest_next;
    logic [7:0]      r_len, w_len_next;
    logic [8:0]      r_cnt, w_cnt_next;
    logic [8:0]      r_idx, w_idx_next;
    logic [7:0]      r_sum, w_sum_next;
    logic [TW-1:0]   r_timer, w_timer_next;
    logic [BW-1:0]   r_backoff, w_backoff_next;
    logic [3:0]      r_retry, w_retry_next;
    logic [15:0]     r_lfsr;
    logic            r_s_ready;
    logic [7:0]      r_d_tx, w_d_tx_next;
    logic            r_d_tx_ready, w_d_tx_ready_next;
    logic            r_busy, r_done, w_done_next, r_fail, w_fail_next;

    logic [7:0]      r_buf [MAX_LEN];
    logic [7:0]      r_rd_data;
    logic            w_accept;
    logic [AW-1:0]   w_wr_addr, w_rd_addr;
    logic [7:0]      w_byte;
    logic [8:0]      w_frame_end;
    logic            w_attempt_fail;
    logic [3:0]      w_retry_inc;
    logic [9:0]      w_mask, w_k;

    assign w_accept    = s_valid & r_s_ready;
    assign w_wr_addr   = (r_state == S_IDLE) ? '0 : AW'(r_cnt);
    // Prefetch two indices ahead so the registered read lands as payload byte idx-3 is due.
    assign w_rd_addr   = AW'(r_idx - 9'd2);
    assign w_frame_end = {1'b0, r_len} + 9'd4;
    assign w_retry_inc = r_retry + 4'd1;
    assign w_mask      = (w_retry_inc >= 4'd10) ? 10'h3FF : ((10'd1 << w_retry_inc) - 10'd1);
    assign w_k         = r_lfsr[9:0] & w_mask;

    always_ff @(posedge clk_40mhz) begin
        if (w_accept) begin
            r_buf[w_wr_addr] <= s_data;
        end
        r_rd_data <= r_buf[w_rd_addr];
    end

    always_comb begin
        if (r_idx == 9'd1) begin
            w_byte = MY_ADDR;
        end else if (r_idx == 9'd2) begin
            w_byte = r_len;
        end else if (r_idx == {1'b0, r_len} + 9'd3) begin
            w_byte = ~r_sum;
        end else begin
            w_byte = r_rd_data;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_dest_next       = r_dest;
        w_len_next        = r_len;
        w_cnt_next        = r_cnt;
        w_idx_next        = r_idx;
        w_sum_next        = r_sum;
        w_timer_next      = r_timer;
        w_backoff_next    = r_backoff;
        w_retry_next      = r_retry;
        w_d_tx_next       = r_d_tx;
        w_d_tx_ready_next = 1'b0;
        w_done_next       = 1'b0;
        w_fail_next       = 1'b0;
        w_attempt_fail    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_dest_next = dest_addr;
                    w_cnt_next  = 9'd1;
                    if (s_last || MAX_LEN == 1) begin
                        w_len_next   = 8'd1;
                        w_state_next = S_WAIT_IDLE;
                    end else begin
                        w_state_next = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    w_cnt_next = r_cnt + 9'd1;
                    if (s_last || w_cnt_next == 9'(MAX_LEN)) begin
                        w_len_next   = w_cnt_next[7:0];
                        w_state_next = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (IB) begin
                    w_d_tx_ready_next = 1'b1;
                    w_d_tx_next       = r_dest;
                    w_sum_next        = r_dest;
                    w_idx_next        = 9'd1;
                    w_state_next      = S_SEND;
                end
            end
            S_SEND: begin
                if (CD) begin
                    w_attempt_fail = 1'b1;
                end else if (r_idx == w_frame_end) begin
                    w_timer_next = '0;
                    w_state_next = S_WAIT_RESULT;
                end else begin
                    w_d_tx_ready_next = 1'b1;
                    w_d_tx_next       = w_byte;
                    w_sum_next        = r_sum + w_byte;
                    w_idx_next        = r_idx + 9'd1;
                end
            end
            S_WAIT_RESULT: begin
                if (CD) begin
                    w_attempt_fail = 1'b1;
                end else if (TX_success) begin
                    w_done_next  = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_timer == TW'(RESULT_TIMEOUT - 1)) begin
                    w_attempt_fail = 1'b1;
                end else begin
                    w_timer_next = r_timer + TW'(1);
                end
            end
            S_BACKOFF: begin
                if (r_backoff <= BW'(1)) begin
                    w_state_next = S_WAIT_IDLE;
                end else begin
                    w_backoff_next = r_backoff - BW'(1);
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        // Buffer contents and LEN are kept, so a retransmission is byte-identical.
        if (w_attempt_fail) begin
            if (r_retry == 4'(MAX_RETRY)) begin
                w_fail_next  = 1'b1;
                w_state_next = S_IDLE;
            end else begin
                w_retry_next = w_retry_inc;
                if (w_k == 10'd0) begin
                    w_state_next = S_WAIT_IDLE;
                end else begin
                    w_backoff_next = BW'(w_k) * BW'(SLOT_CYCLES);
                    w_state_next   = S_BACKOFF;
                end
            end
        end

        if (w_state_next == S_IDLE) begin
            w_retry_next = 4'd0;
        end
    end

    always_ff @(posedge clk_40mhz or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_dest       <= 8'd0;
            r_len        <= 8'd0;
            r_cnt        <= 9'd0;
            r_idx        <= 9'd0;
            r_sum        <= 8'd0;
            r_timer      <= '0;
            r_backoff    <= '0;
            r_retry      <= 4'd0;
            r_lfsr       <= LFSR_SEED;
            r_s_ready    <= 1'b1;
            r_d_tx       <= 8'd0;
            r_d_tx_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_dest       <= w_dest_next;
            r_len        <= w_len_next;
            r_cnt        <= w_cnt_next;
            r_idx        <= w_idx_next;
            r_sum        <= w_sum_next;
            r_timer      <= w_timer_next;
            r_backoff    <= w_backoff_next;
            r_retry      <= w_retry_next;
            r_lfsr       <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
            r_s_ready    <= (w_state_next == S_IDLE) || (w_state_next == S_LOAD);
            r_d_tx       <= w_d_tx_next;
            r_d_tx_ready <= w_d_tx_ready_next;
            r_busy       <= (w_state_next != S_IDLE);
            r_done       <= w_done_next;
            r_fail       <= w_fail_next;
        end
    end

    assign s_ready     = r_s_ready;
    assign D_TX        = r_d_tx;
    assign D_TX_ready  = r_d_tx_ready;
    assign busy        = r_busy;
    assign done        = r_done;
    assign fail        = r_fail;
    assign retry_count = r_retry;
endmodule

// File: tb/tb_mac_tx_framer.sv
// Directed-plus-random bench for mac_tx_framer with a PHY responder and a frame-level reference model.
`timescale 1ns/1ps
module tb_mac_tx_framer;
    localparam int SLOT = 256;

    logic       clk_40mhz = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] s_data = 8'd0;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       s_ready;
    logic [7:0] dest_addr = 8'd0;
    logic [7:0] D_TX;
    logic       D_TX_ready;
    logic       IB = 1'b1;
    logic       CD = 1'b0;
    logic       TX_success = 1'b0;
    logic       busy, done, fail;
    logic [3:0] retry_count;

    mac_tx_framer dut (
        .clk_40mhz(clk_40mhz), .reset(reset),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .dest_addr(dest_addr),
        .D_TX(D_TX), .D_TX_ready(D_TX_ready),
        .IB(IB), .CD(CD), .TX_success(TX_success),
        .busy(busy), .done(done), .fail(fail), .retry_count(retry_count)
    );

    always #5 clk_40mhz = ~clk_40mhz;

    int errors = 0, checks = 0, cyc = 0;
    logic [7:0] pl[$];
    logic [7:0] exp_q[$];
    logic [7:0] frame_bytes[$];
    int frame_lens[$];
    int gaps[$];
    int frame_cnt, cur_len, low_cnt, end_cyc, done_cnt, fail_cnt, max_retry;
    int cd_attempts, sready_viol, accepted;
    bit prev_rdy, aborted, watch_sready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_state();
        frame_bytes.delete(); frame_lens.delete(); gaps.delete();
        frame_cnt = 0; cur_len = 0; low_cnt = 0; end_cyc = -100;
        done_cnt = 0; fail_cnt = 0; max_retry = 0;
        cd_attempts = 0; sready_viol = 0; watch_sready = 0;
        prev_rdy = 0; aborted = 0;
    endtask

    // One clock: observe outputs after the edge, then act as the PHY for the next edge.
    task automatic tick();
        @(posedge clk_40mhz); #1;
        cyc++;
        CD = 1'b0;
        TX_success = 1'b0;
        if (D_TX_ready) begin
            if (!prev_rdy) begin
                if (frame_cnt > 0) gaps.push_back(low_cnt);
                frame_cnt++;
                cur_len = 0;
                aborted = 0;
            end
            frame_bytes.push_back(D_TX);
            cur_len++;
            if (cur_len == 6 && frame_cnt <= cd_attempts) begin
                CD = 1'b1;
                aborted = 1;
            end
        end else begin
            if (prev_rdy) begin
                frame_lens.push_back(cur_len);
                end_cyc = cyc;
                low_cnt = 0;
            end
            low_cnt++;
            if (frame_cnt > 0 && !aborted && cyc == end_cyc + 9) TX_success = 1'b1;
        end
        done_cnt += int'(done);
        fail_cnt += int'(fail);
        if (int'(retry_count) > max_retry) max_retry = int'(retry_count);
        if (watch_sready && done_cnt == 0 && s_ready) sready_viol++;
        prev_rdy = D_TX_ready;
    endtask

    task automatic send(input logic [7:0] d, input int n_offer, input bit use_last, input bit bubbles);
        int i = 0;
        int bound = bubbles ? 4 * n_offer + 20 : n_offer + 10;
        bit acc;
        for (int c = 0; c < bound && i < n_offer; c++) begin
            s_valid   = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_data    = pl[i];
            s_last    = use_last && (i == n_offer - 1);
            dest_addr = (i == 0) ? d : ~d;
            acc = s_valid && s_ready;
            tick();
            if (acc) i++;
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        accepted = i;
    endtask

    task automatic wait_outcome(input int budget);
        int start = done_cnt + fail_cnt;
        int c = 0;
        while (done_cnt + fail_cnt == start && c < budget) begin
            tick();
            c++;
        end
        repeat (20) tick();
        check("outcome_count", done_cnt + fail_cnt - start, 1);
    endtask

    // Reference frame: DEST, SRC, LEN, payload, then NOT of the byte sum so far.
    task automatic build_exp(input logic [7:0] d, input int n);
        logic [7:0] s;
        logic [7:0] ln;
        ln = n[7:0];
        exp_q.delete();
        exp_q.push_back(d);
        exp_q.push_back(8'h11);
        exp_q.push_back(ln);
        for (int j = 0; j < n; j++) exp_q.push_back(pl[j]);
        s = 8'd0;
        foreach (exp_q[j]) s = s + exp_q[j];
        exp_q.push_back(~s);
    endtask

    task automatic compare_frame(input string tag, input int off, input int nbytes);
        logic [31:0] obs;
        for (int j = 0; j < nbytes; j++) begin
            obs = (off + j < frame_bytes.size()) ? {24'd0, frame_bytes[off + j]} : 32'hDEAD;
            check($sformatf("%s_byte%0d", tag, j), obs, {24'd0, exp_q[j]});
        end
    endtask

    function automatic bit gap_ok(input int g, input int n);
        return (g >= 1) && ((g - 1) % SLOT == 0) && ((g - 1) / SLOT <= (1 << n) - 1);
    endfunction

    initial begin
        int bad;
        int n;
        logic [7:0] d;
        clear_state();
        repeat (3) @(posedge clk_40mhz);
        #1;
        check("rst_s_ready", s_ready, 1);
        check("rst_D_TX", D_TX, 0);
        check("rst_D_TX_ready", D_TX_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fail", fail, 0);
        check("rst_retry", retry_count, 0);
        reset = 1'b0;
        repeat (2) tick();

        // 64-byte ramp payload to dest 22
        clear_state();
        pl.delete();
        for (int i = 0; i < 64; i++) pl.push_back(8'(i));
        send(8'h22, 64, 1, 0);
        wait_outcome(500);
        build_exp(8'h22, 64);
        check("t1_frames", frame_cnt, 1);
        check("t1_len", frame_lens.size() > 0 ? frame_lens[0] : -1, 68);
        check("t1_chk", exp_q[67], 8'hAC);
        compare_frame("t1", 0, 68);
        check("t1_done", done_cnt, 1);
        check("t1_fail", fail_cnt, 0);
        check("t1_retry", max_retry, 0);

        // single-byte frame, held off by IB=0 first
        clear_state();
        IB = 1'b0;
        pl.delete();
        pl.push_back(8'h5A);
        send(8'h01, 1, 1, 0);
        watch_sready = 1;
        repeat (20) tick();
        check("t2_ib_hold", frame_cnt, 0);
        check("t2_busy", busy, 1);
        IB = 1'b1;
        wait_outcome(500);
        build_exp(8'h01, 1);
        check("t2_chk", exp_q[4], 8'h92);
        check("t2_len", frame_lens.size() > 0 ? frame_lens[0] : -1, 5);
        compare_frame("t2", 0, 5);
        check("t2_sready_low", sready_viol, 0);
        check("t2_done", done_cnt, 1);

        // one collision then success
        clear_state();
        cd_attempts = 1;
        pl.delete();
        for (int i = 0; i < 20; i++) pl.push_back(8'($urandom));
        send(8'h22, 20, 1, 0);
        wait_outcome(3000);
        build_exp(8'h22, 20);
        check("t3_frames", frame_cnt, 2);
        check("t3_abort_len", frame_lens.size() > 0 ? frame_lens[0] : -1, 6);
        check("t3_full_len", frame_lens.size() > 1 ? frame_lens[1] : -1, 24);
        check("t3_backoff", gaps.size() > 0 ? gap_ok(gaps[0], 1) : 1'b0, 1);
        compare_frame("t3a", 0, 6);
        compare_frame("t3b", 6, 24);
        check("t3_retry", max_retry, 1);
        check("t3_done", done_cnt, 1);
        check("t3_retry_clr", retry_count, 0);

        // collision on every attempt
        clear_state();
        cd_attempts = 99;
        pl.delete();
        for (int i = 0; i < 10; i++) pl.push_back(8'($urandom));
        send(8'h5C, 10, 1, 0);
        wait_outcome(70000);
        check("t4_frames", frame_cnt, 8);
        check("t4_fail", fail_cnt, 1);
        check("t4_done", done_cnt, 0);
        check("t4_retry", max_retry, 7);
        bad = 0;
        foreach (gaps[i]) if (!gap_ok(gaps[i], i + 1)) bad++;
        foreach (frame_lens[i]) if (frame_lens[i] != 6) bad++;
        check("t4_gaps_lens", bad, 0);
        check("t4_busy_after", busy, 0);

        // 70 bytes without s_last: truncated at MAX_LEN
        clear_state();
        pl.delete();
        for (int i = 0; i < 70; i++) pl.push_back(8'($urandom));
        send(8'h3C, 70, 0, 0);
        check("t5_accepted", accepted, 64);
        wait_outcome(500);
        build_exp(8'h3C, 64);
        check("t5_len_byte", frame_bytes.size() > 2 ? frame_bytes[2] : 8'hFF, 8'h40);
        check("t5_len", frame_lens.size() > 0 ? frame_lens[0] : -1, 68);
        compare_frame("t5", 0, 68);

        // random payloads with valid bubbles
        for (int r = 0; r < 3; r++) begin
            clear_state();
            n = $urandom_range(1, 64);
            d = 8'($urandom);
            pl.delete();
            for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
            send(d, n, 1, 1);
            check($sformatf("r%0d_accepted", r), accepted, n);
            wait_outcome(1000);
            build_exp(d, n);
            check($sformatf("r%0d_len", r), frame_lens.size() > 0 ? frame_lens[0] : -1, n + 4);
            compare_frame($sformatf("r%0d", r), 0, n + 4);
            check($sformatf("r%0d_done", r), done_cnt, 1);
        end

        // asynchronous reset in the middle of a transmission
        clear_state();
        pl.delete();
        for (int i = 0; i < 30; i++) pl.push_back(8'($urandom));
        send(8'h33, 30, 1, 0);
        for (int c = 0; c < 200 && !(D_TX_ready && cur_len == 10); c++) tick();
        check("t6_midsend", D_TX_ready, 1);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_ready", D_TX_ready, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        repeat (2) @(posedge clk_40mhz);
        #1 reset = 1'b0;
        clear_state();
        pl.delete();
        for (int i = 0; i < 3; i++) pl.push_back(8'($urandom));
        send(8'h44, 3, 1, 0);
        wait_outcome(500);
        build_exp(8'h44, 3);
        check("t6_len", frame_lens.size() > 0 ? frame_lens[0] : -1, 7);
        compare_frame("t6", 0, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
